// File: rtl/axi_wr_responder_pkg.sv
// axi_wr_responder_pkg: shared AXI widths, write-response codes and the
// responder FSM state encoding.
// Width defaults can be overridden by defining AXI_ADDR_WIDTH, AXI_DATA_WIDTH,
// OFFSET_WIDTH and AXI_ID_WIDTH on the tool command line.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_wr_responder_pkg;
  localparam int AXI_ADDR_W    = `AXI_ADDR_WIDTH;
  localparam int AXI_DATA_W    = `AXI_DATA_WIDTH;
  localparam int LINE_OFFSET_W = `OFFSET_WIDTH;
  localparam int AXI_ID_W      = `AXI_ID_WIDTH;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // One write in flight: address and/or data held, then push, then respond.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_PUSH = 3'd3,
    S_RESP = 3'd4
  } state_t;
endpackage

// File: rtl/axi_wr_responder.sv
// axi_wr_responder: single-beat AXI write slave. Captures AW and W in either
// order, pushes the line-aligned {addr, data} entry into a downstream FIFO,
// then returns a B response and counts completed writes.
// Optional: define WR_RESP_ALIGN_CHECK_EN to reject misaligned addresses with
// SLVERR instead of pushing them.
module axi_wr_responder
  import axi_wr_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = AXI_ADDR_W,
  parameter int DATA_WIDTH   = AXI_DATA_W,
  parameter int OFFSET_WIDTH = LINE_OFFSET_W,
  parameter int ID_WIDTH     = AXI_ID_W,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ID_WIDTH-1:0]            awid_i,
  input  logic                           awvalid_i,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  output logic                           awready_o,
  input  logic [ID_WIDTH-1:0]            wid_i,
  input  logic                           wvalid_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic                           wready_o,
  output logic [ID_WIDTH-1:0]            bid_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  output logic                           wren_o,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] data_o,
  input  logic                           afull_i,
  output logic [CNT_WIDTH-1:0]           wr_cnt_o
);

  // Clears the line-offset bits so the FIFO always sees line addresses.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic [ID_WIDTH-1:0]    bid_reg;
  logic [1:0]             bresp_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic                   misalign_reg;
  logic                   aw_hs, w_hs, b_hs;
  logic                   unused_wid;

  // The write-data ID is accepted but never compared against the AW ID.
  assign unused_wid = ^wid_i;

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;
  assign b_hs  = bvalid_o & bready_i;

`ifdef WR_RESP_ALIGN_CHECK_EN
  // Flag a misaligned address at AW capture; it is answered with SLVERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_reg <= 1'b0;
    else if (aw_hs)
      misalign_reg <= |awaddr_i[OFFSET_WIDTH-1:0];
  end
`else
  assign misalign_reg = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic: collect AW and W in either order, push, then respond.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (aw_hs && w_hs)
          state_next = S_PUSH;
        else if (aw_hs)
          state_next = S_ADDR;
        else if (w_hs)
          state_next = S_DATA;
      end
      S_ADDR: if (w_hs) state_next = S_PUSH;
      S_DATA: if (aw_hs) state_next = S_PUSH;
      S_PUSH: if (misalign_reg || !afull_i) state_next = S_RESP;
      S_RESP: if (bready_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only; readies never depend on the valids.
  always_comb begin
    awready_o = (state_reg == S_IDLE) || (state_reg == S_DATA);
    wready_o  = (state_reg == S_IDLE) || (state_reg == S_ADDR);
    bvalid_o  = (state_reg == S_RESP);
    wren_o    = (state_reg == S_PUSH) && !afull_i && !misalign_reg;
  end

  // Holding registers for the in-flight write and its response code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      bid_reg   <= '0;
      bresp_reg <= BRESP_OKAY;
    end else begin
      if (aw_hs) begin
        addr_reg <= awaddr_i;
        bid_reg  <= awid_i;
      end
      if (w_hs)
        data_reg <= wdata_i;
      if (state_reg == S_PUSH && state_next == S_RESP)
        bresp_reg <= misalign_reg ? BRESP_SLVERR : BRESP_OKAY;
    end
  end

  // Completed-write counter, advanced on each B handshake and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (b_hs)
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign data_o   = {addr_reg & LINE_MASK, data_reg};
  assign bid_o    = bid_reg;
  assign bresp_o  = bresp_reg;
  assign wr_cnt_o = cnt_reg;

endmodule
